// File: rtl/shift_right_seq_pkg.sv
// Shared types and constants for the sequential right shifter.
// The build option SHIFT_RIGHT_SEQ_SKIP_EN is consumed by shift_right_seq.sv.
package shift_right_seq_pkg;

  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int NUM_STAGES = 5;

  // Shift distance applied by stage k; stage k is controlled by shamt[SHAMT_W-1-k].
  localparam int STAGE_DIST [NUM_STAGES] = '{16, 8, 4, 2, 1};

  // Single-hot mask of the shamt bit that controls stage 0.
  localparam logic [SHAMT_W-1:0] STAGE0_BIT = {1'b1, {(SHAMT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index of the first stage whose control bit is set (highest shamt bit first).
  // Returns 0 for an all-zero mask; callers never use it in that case.
  function automatic logic [2:0] lead_stage(input logic [SHAMT_W-1:0] m);
    lead_stage = 3'd0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (m[SHAMT_W-1-k]) lead_stage = 3'(k);
    end
  endfunction

endpackage

// File: rtl/shift_right_seq_if.sv
// Request/result bundle of the sequential right shifter.
// master drives the request side, slave is the shifter itself.
interface shift_right_seq_if;
  import shift_right_seq_pkg::*;

  logic               start;
  logic [DATA_W-1:0]  data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  data_out;

  modport master (
    output start, data_in, shamt, arith,
    input  busy, done, data_out
  );

  modport slave (
    input  start, data_in, shamt, arith,
    output busy, done, data_out
  );

endinterface

// File: rtl/shift_right_stage.sv
// One fixed-distance right-shift stage: shift by DIST with the given fill
// bit when enabled, otherwise pass the operand through unchanged.
module shift_right_stage
  import shift_right_seq_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [DATA_W-1:0] in,
  input  logic              en,
  input  logic              fill,
  output logic [DATA_W-1:0] out
);

  assign out = en ? {{DIST{fill}}, in[DATA_W-1:DIST]} : in;

endmodule

// File: rtl/shift_right_seq.sv
// Sequential barrel shifter: one binary-weighted stage (16,8,4,2,1) per clock.
// Build option SHIFT_RIGHT_SEQ_SKIP_EN: stages whose shamt bit is 0 take no
// cycle, so latency equals popcount(shamt) and shamt=0 finishes at acceptance.
// Results are identical with and without the option.
module shift_right_seq
  import shift_right_seq_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  shift_right_seq_if.slave   bus
);

  state_t             state, state_nx;
  logic [DATA_W-1:0]  work;
  logic [SHAMT_W-1:0] shamt_q;
  logic               fill_q;
  logic [2:0]         cnt;
  logic [DATA_W-1:0]  dout_q;
  logic               done_q;
  logic               busy_q;

  logic [2:0]         stage_sel;
  logic [SHAMT_W-1:0] stage_bit;
  logic               stage_en;
  logic               last_stage;
  logic [DATA_W-1:0]  stage_out [NUM_STAGES];
  logic [DATA_W-1:0]  sel_out;

  // Choose which stage acts this cycle and whether it is the final one.
  always_comb begin
`ifdef SHIFT_RIGHT_SEQ_SKIP_EN
    stage_sel  = lead_stage(shamt_q);
    stage_bit  = STAGE0_BIT >> stage_sel;
    last_stage = (shamt_q & ~stage_bit) == '0;
`else
    stage_sel  = cnt;
    stage_bit  = STAGE0_BIT >> stage_sel;
    last_stage = (cnt == 3'(NUM_STAGES - 1));
`endif
    stage_en   = |(shamt_q & stage_bit);
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    shift_right_stage #(.DIST(STAGE_DIST[g])) u_stage (
      .in   (work),
      .en   (stage_en),
      .fill (fill_q),
      .out  (stage_out[g])
    );
  end

  // Route the output of the active stage to the working register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_out = work;
    case (stage_sel)
      3'd0:    sel_out = stage_out[0];
      3'd1:    sel_out = stage_out[1];
      3'd2:    sel_out = stage_out[2];
      3'd3:    sel_out = stage_out[3];
      3'd4:    sel_out = stage_out[4];
      default: sel_out = work;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic: start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef SHIFT_RIGHT_SEQ_SKIP_EN
          state_nx = (bus.shamt == '0) ? DONE : SHIFT;
`else
          state_nx = SHIFT;
`endif
        end
      end
      SHIFT:   if (last_stage) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: datapath registers are reset too, since data_out=0 after reset is visible at the port.
    if (!resetn) begin
      work    <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
      cnt     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= (state_nx == DONE);
      busy_q <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            work    <= bus.data_in;
            shamt_q <= bus.shamt;
            fill_q  <= bus.arith & bus.data_in[DATA_W-1];
            cnt     <= '0;
`ifdef SHIFT_RIGHT_SEQ_SKIP_EN
            if (bus.shamt == '0) dout_q <= bus.data_in;
`endif
          end
        end
        SHIFT: begin
          work <= sel_out;
          cnt  <= cnt + 3'd1;
`ifdef SHIFT_RIGHT_SEQ_SKIP_EN
          shamt_q <= shamt_q & ~stage_bit;
`endif
          if (last_stage) dout_q <= sel_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq with a result scoreboard.
// Honours SHIFT_RIGHT_SEQ_SKIP_EN for the expected latency.
module tb_shift_right_seq;

  logic clock;
  logic resetn;

  shift_right_seq_if bus ();

  shift_right_seq dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  logic [31:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh, input logic ar);
    if (ar) return 32'($signed(d) >>> sh);
    else    return d >> sh;
  endfunction

  function automatic int latency(input logic [4:0] sh);
`ifdef SHIFT_RIGHT_SEQ_SKIP_EN
    return $countones(sh);
`else
    return 5;
`endif
  endfunction

  // One operation from acceptance edge E0 to the edge after DONE.
  // poke pulses start so it is sampled at E2 and at the edge leaving DONE.
  task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                        input logic [31:0] exp, input bit poke);
    int          lat;
    logic [31:0] popped;
    lat    = latency(sh);
    popped = exp;
    sb.push_back(exp);
    bus.data_in = d;
    bus.shamt   = sh;
    bus.arith   = ar;
    bus.start   = 1'b1;
    @(posedge clock); #1;
    bus.start   = 1'b0;
    bus.data_in = $urandom;
    bus.shamt   = 5'($urandom);
    bus.arith   = 1'($urandom);
    for (int n = 0; n <= lat; n++) begin
      if (n > 0) begin
        @(posedge clock); #1;
      end
      check("busy", 32'(bus.busy), 32'd1);
      if (n < lat) begin
        check("done_early", 32'(bus.done), 32'd0);
        check("data_out_held", bus.data_out, last_out);
      end else begin
        check("done", 32'(bus.done), 32'd1);
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else                popped = sb.pop_front();
        check("data_out", bus.data_out, popped);
        last_out = popped;
      end
      bus.start = poke && (n == 1 || n == lat);
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("done_fall", 32'(bus.done), 32'd0);
    check("data_out_after", bus.data_out, last_out);
  endtask

  initial begin
    logic [31:0] d;
    logic [4:0]  sh;
    logic        ar;

    resetn      = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.shamt   = '0;
    bus.arith   = 1'b0;
    last_out    = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Fixed vectors, first one accepted on the first edge after release.
    run_op(32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F, 1'b0);
    run_op(32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F, 1'b0);
    run_op(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0);
    run_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0);
    run_op(32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 1'b0);

    // Start while busy and during DONE must be ignored.
    run_op(32'hC3A5_0F11, 5'd13, 1'b1, 32'hFFFE_1D28, 1'b1);
    repeat (2) begin
      @(posedge clock); #1;
      check("no_extra_done", 32'(bus.done), 32'd0);
      check("no_extra_busy", 32'(bus.busy), 32'd0);
    end

    // Reset at E3 of an operation.
    bus.data_in = 32'h1234_5678;
    bus.shamt   = 5'h1F;
    bus.arith   = 1'b0;
    bus.start   = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_data_out", bus.data_out, 32'd0);
    last_out = '0;
    repeat (3) begin
      @(posedge clock); #1;
      check("midrst_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clock);
    resetn = 1'b1;
    run_op(32'hF000_0000, 5'd3, 1'b1, 32'hFE00_0000, 1'b0);

    // Random operands against the reference model.
    for (int i = 0; i < 10; i++) begin
      d  = $urandom;
      sh = 5'($urandom);
      ar = 1'($urandom);
      run_op(d, sh, ar, model(d, sh, ar), 1'b0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
